// File: rtl/flash_spi_pkg.sv
// Shared definitions for the SPI-flash driver: operation types, FSM encoding
// and the flash opcodes used by the controller and benches.
package flash_spi_pkg;

    localparam logic [2:0] SPI_INS   = 3'd0;
    localparam logic [2:0] SPI_READ  = 3'd1;
    localparam logic [2:0] SPI_WRITE = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_TAIL,
        S_CS_GAP
    } state_t;

    localparam logic [7:0] OP_PAGE_PROG   = 8'h02;
    localparam logic [7:0] OP_READ_DATA   = 8'h03;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;
    localparam logic [7:0] OP_WRITE_EN    = 8'h06;
    localparam logic [7:0] OP_SECT_ERASE  = 8'h20;

endpackage

// File: rtl/spi_bit_timer.sv
// SCLK generator: P_CLK_DIV clocks low then P_CLK_DIV clocks high per bit,
// for n bits after a start pulse, with edge strobes and the running bit index.
module spi_bit_timer #(
    parameter int P_CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n,
    output logic        sclk,
    output logic        rise,
    output logic        fall,
    output logic [15:0] bit_idx,
    output logic        done
);
    localparam int DW = $clog2(P_CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(P_CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic          half_end;
    logic          last_bit;

    assign half_end = active && (div_cnt == DIV_LAST);
    assign last_bit = (bit_idx == n - 16'd1);

    // rise marks the first high cycle (MISO sample point); fall and done mark
    // the last high cycle, so the next registered MOSI bit lines up with SCLK low.
    assign rise = active && sclk && (div_cnt == '0);
    assign fall = half_end && sclk && !last_bit;
    assign done = half_end && sclk && last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_idx <= 16'd0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_idx <= 16'd0;
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    if (last_bit) begin
                        active <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 16'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_spi_drv.sv
// SPI mode-0 master: sends an MSB-first instruction, then streams payload
// bytes from the write FIFO or returns received bytes, one command per handshake.
module flash_spi_drv
    import flash_spi_pkg::*;
#(
    parameter int P_USER_OP_LEN = 32,
    parameter int P_CLK_DIV     = 4,
    parameter int P_CS_HIGH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [P_USER_OP_LEN-1:0] i_user_op_data,
    input  logic [8:0]               i_user_op_len,
    input  logic [2:0]               i_user_op_type,
    input  logic                     i_user_op_valid,
    input  logic [15:0]              i_user_clk_len,
    output logic                     o_user_ready,
    input  logic [7:0]               i_user_write_data,
    output logic                     o_user_write_req,
    output logic [7:0]               o_user_read_data,
    output logic                     o_user_read_valid,
    output logic                     o_spi_clk,
    output logic                     o_spi_cs,
    output logic                     o_spi_mosi,
    input  logic                     i_spi_miso
);
    localparam logic [8:0]  OP_MAX   = 9'(P_USER_OP_LEN);
    localparam logic [15:0] DIV_LAST = 16'(P_CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(P_CS_HIGH - 1);

    state_t                   state;
    logic [P_USER_OP_LEN-1:0] tx_sr;
    logic [15:0]              n_q;
    logic [15:0]              len_q;
    logic [15:0]              cnt;
    logic [15:0]              len_in;
    logic [15:0]              n_in;
    logic [15:0]              next_k;
    logic                     is_read;
    logic                     is_write;
    logic                     req_d1;
    logic                     accept;
    logic                     capture;
    logic                     boundary;
    logic [7:0]               byte_sr;
    logic [7:0]               rx_sr;
    logic [2:0]               rx_cnt;
    logic                     t_start;
    logic                     t_rise;
    logic                     t_fall;
    logic                     t_done;
    logic [15:0]              t_bit;

    assign accept = i_user_op_valid && o_user_ready;
    assign len_in = (i_user_op_len > OP_MAX) ? 16'(OP_MAX) : 16'(i_user_op_len);
    assign n_in   = (i_user_clk_len > len_in) ? i_user_clk_len : len_in;
    assign next_k = t_bit + 16'd1;

    // Next bit closes a byte (last instruction bit, then every 8th) and data still follows.
    assign boundary = (next_k + 16'd1 >= len_q)
                   && (((next_k + 16'd1 - len_q) & 16'd7) == 16'd0)
                   && (next_k < n_q - 16'd1);
    assign capture  = (state == S_SHIFT) && t_rise && is_read && (t_bit >= len_q);
    assign t_start  = (state == S_LOAD) && (n_q != 16'd0);

    spi_bit_timer #(
        .P_CLK_DIV (P_CLK_DIV)
    ) u_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .start   (t_start),
        .n       (n_q),
        .sclk    (o_spi_clk),
        .rise    (t_rise),
        .fall    (t_fall),
        .bit_idx (t_bit),
        .done    (t_done)
    );

    always_ff @(posedge i_clk) begin
        if (accept) begin
            tx_sr <= i_user_op_data << 1;
        end else if ((state == S_SHIFT) && t_fall && (next_k < len_q)) begin
            tx_sr <= tx_sr << 1;
        end
        if (req_d1) begin
            byte_sr <= i_user_write_data;
        end else if ((state == S_SHIFT) && t_fall && (next_k >= len_q)) begin
            byte_sr <= byte_sr << 1;
        end
        if (capture) begin
            rx_sr <= {rx_sr[6:0], i_spi_miso};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= S_IDLE;
            o_user_ready      <= 1'b1;
            o_spi_cs          <= 1'b1;
            o_spi_mosi        <= 1'b0;
            o_user_write_req  <= 1'b0;
            o_user_read_valid <= 1'b0;
            o_user_read_data  <= 8'd0;
            req_d1            <= 1'b0;
            cnt               <= 16'd0;
            rx_cnt            <= 3'd0;
            n_q               <= 16'd0;
            len_q             <= 16'd0;
            is_read           <= 1'b0;
            is_write          <= 1'b0;
        end else begin
            o_user_write_req  <= 1'b0;
            o_user_read_valid <= 1'b0;
            req_d1            <= o_user_write_req;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        o_user_ready     <= 1'b0;
                        o_spi_cs         <= (n_in == 16'd0);
                        o_spi_mosi       <= (len_in != 16'd0) ? i_user_op_data[P_USER_OP_LEN-1] : 1'b0;
                        o_user_write_req <= (i_user_op_type == SPI_WRITE) && (len_in == 16'd1) && (n_in > 16'd1);
                        n_q              <= n_in;
                        len_q            <= len_in;
                        is_read          <= (i_user_op_type == SPI_READ);
                        is_write         <= (i_user_op_type == SPI_WRITE);
                        rx_cnt           <= 3'd0;
                        state            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= 16'd0;
                    state <= (n_q == 16'd0) ? S_CS_GAP : S_SHIFT;
                end
                S_SHIFT: begin
                    if (t_fall) begin
                        if (next_k < len_q) begin
                            o_spi_mosi <= tx_sr[P_USER_OP_LEN-1];
                        end else begin
                            o_spi_mosi <= is_write && byte_sr[7];
                        end
                        o_user_write_req <= is_write && boundary;
                    end
                    if (capture) begin
                        rx_cnt <= rx_cnt + 3'd1;
                        if (rx_cnt == 3'd7) begin
                            o_user_read_data  <= {rx_sr[6:0], i_spi_miso};
                            o_user_read_valid <= 1'b1;
                        end
                    end
                    if (t_done) begin
                        cnt   <= 16'd0;
                        state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (cnt == DIV_LAST) begin
                        o_spi_cs   <= 1'b1;
                        o_spi_mosi <= 1'b0;
                        cnt        <= 16'd0;
                        state      <= S_CS_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CS_GAP: begin
                    if (cnt == GAP_LAST) begin
                        o_user_ready <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_spi_drv.sv
// Directed bench for flash_spi_drv: SPI slave/FIFO models on the falling clock
// edge, per-command counters, and hand-computed expectations.
module tb_flash_spi_drv;
    import flash_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_data;
    logic [8:0]  op_len;
    logic [2:0]  op_type;
    logic        op_valid;
    logic [15:0] clk_len;
    logic        ready;
    logic [7:0]  write_data = 8'd0;
    logic        write_req;
    logic [7:0]  read_data;
    logic        read_valid;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    always #5 clk = ~clk;

    flash_spi_drv #(
        .P_USER_OP_LEN (32),
        .P_CLK_DIV     (4),
        .P_CS_HIGH     (4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_user_op_data    (op_data),
        .i_user_op_len     (op_len),
        .i_user_op_type    (op_type),
        .i_user_op_valid   (op_valid),
        .i_user_clk_len    (clk_len),
        .o_user_ready      (ready),
        .i_user_write_data (write_data),
        .o_user_write_req  (write_req),
        .o_user_read_data  (read_data),
        .o_user_read_valid (read_valid),
        .o_spi_clk         (spi_clk),
        .o_spi_cs          (spi_cs),
        .o_spi_mosi        (spi_mosi),
        .i_spi_miso        (spi_miso)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-command observation, cleared when the bench issues a new command.
    int          cmd_id = 0;
    int          seen_id = 0;
    int          rises = 0;
    int          cs_low = 0;
    int          busy = 0;
    int          rv_cnt = 0;
    int          req_cnt = 0;
    int          wr_idx = 0;
    int          cur_len = 0;
    logic [63:0] mosi_log = '0;
    logic [63:0] miso_bits = '0;
    logic [7:0]  rd_log [4];
    logic [7:0]  wr_fifo [2];
    logic        prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (cmd_id != seen_id) begin
            seen_id  = cmd_id;
            rises    = 0;
            cs_low   = 0;
            busy     = 0;
            rv_cnt   = 0;
            req_cnt  = 0;
            wr_idx   = 0;
            mosi_log = '0;
            for (int i = 0; i < 4; i++) rd_log[i] = 8'h00;
        end
        if (!spi_cs) cs_low++;
        if (!ready) busy++;
        if (read_valid) begin
            if (rv_cnt < 4) rd_log[rv_cnt] = read_data;
            rv_cnt++;
        end
        if (write_req) begin
            write_data = (wr_idx < 2) ? wr_fifo[wr_idx] : 8'hEE;
            req_cnt++;
            wr_idx++;
        end
        if (spi_clk && !prev_sclk) begin
            mosi_log = {mosi_log[62:0], spi_mosi};
            rises++;
        end
        // Slave shifts its next bit out after each falling SCLK edge.
        if (!spi_clk && prev_sclk) begin
            if (rises >= cur_len && (rises - cur_len) < 64)
                spi_miso = miso_bits[63 - (rises - cur_len)];
            else
                spi_miso = 1'b0;
        end
        prev_sclk = spi_clk;
    end

    task automatic send(input logic [31:0] d, input logic [8:0] l, input logic [2:0] t,
                        input logic [15:0] c);
        @(negedge clk);
        cmd_id++;
        op_data  = d;
        op_len   = l;
        op_type  = t;
        clk_len  = c;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_data  = 32'hFFFF_FFFF;
        op_len   = 9'h1FF;
        op_type  = 3'd7;
        clk_len  = 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_val("done_timeout", 64'(ready), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        op_data  = '0;
        op_len   = '0;
        op_type  = '0;
        op_valid = 1'b0;
        clk_len  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'(ready), 64'(1));
        check_val("rst_cs", 64'(spi_cs), 64'(1));
        check_val("rst_sclk", 64'(spi_clk), 64'(0));
        check_val("rst_mosi", 64'(spi_mosi), 64'(0));
        check_val("rst_wreq", 64'(write_req), 64'(0));
        check_val("rst_rvalid", 64'(read_valid), 64'(0));
        check_val("rst_rdata", 64'(read_data), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write enable: CS low = LOAD + 8*8 + tail 4, ready back 4 gap cycles later.
        cur_len = 8;
        miso_bits = '0;
        send({OP_WRITE_EN, 24'hABCDEF}, 9'd8, SPI_INS, 16'd8);
        check_val("ins_ready_t1", 64'(ready), 64'(0));
        check_val("ins_cs_t1", 64'(spi_cs), 64'(0));
        wait_done();
        check_val("ins_rises", 64'(rises), 64'(8));
        check_val("ins_mosi", 64'(mosi_log[7:0]), 64'(8'h06));
        check_val("ins_cs_low", 64'(cs_low), 64'(69));
        check_val("ins_busy", 64'(busy), 64'(73));
        check_val("ins_rvalid", 64'(rv_cnt), 64'(0));
        check_val("ins_wreq", 64'(req_cnt), 64'(0));

        // Read status register, slave answers 0x03.
        cur_len = 8;
        miso_bits = {8'h03, 56'h0};
        send({OP_READ_STATUS, 24'h0}, 9'd8, SPI_READ, 16'd16);
        wait_done();
        check_val("rsr_rises", 64'(rises), 64'(16));
        check_val("rsr_mosi", 64'(mosi_log[15:0]), 64'(16'h0500));
        check_val("rsr_cs_low", 64'(cs_low), 64'(133));
        check_val("rsr_rvalid", 64'(rv_cnt), 64'(1));
        check_val("rsr_rdata", 64'(rd_log[0]), 64'(8'h03));

        // Read four data bytes after a 32-bit instruction.
        cur_len = 32;
        miso_bits = {32'hA55A_FF00, 32'h0};
        send({OP_READ_DATA, 24'h001000}, 9'd32, SPI_READ, 16'd64);
        wait_done();
        check_val("rd_rises", 64'(rises), 64'(64));
        check_val("rd_mosi", 64'(mosi_log), 64'h0300_1000_0000_0000);
        check_val("rd_cs_low", 64'(cs_low), 64'(517));
        check_val("rd_rvalid", 64'(rv_cnt), 64'(4));
        check_val("rd_byte0", 64'(rd_log[0]), 64'(8'hA5));
        check_val("rd_byte1", 64'(rd_log[1]), 64'(8'h5A));
        check_val("rd_byte2", 64'(rd_log[2]), 64'(8'hFF));
        check_val("rd_byte3", 64'(rd_log[3]), 64'(8'h00));

        // Page program with two payload bytes from the FIFO.
        cur_len = 32;
        miso_bits = '1;
        wr_fifo[0] = 8'h12;
        wr_fifo[1] = 8'h34;
        send({OP_PAGE_PROG, 24'h000100}, 9'd32, SPI_WRITE, 16'd48);
        wait_done();
        check_val("wr_rises", 64'(rises), 64'(48));
        check_val("wr_wreq", 64'(req_cnt), 64'(2));
        check_val("wr_mosi_op", 64'(mosi_log[47:16]), 64'h0200_0100);
        check_val("wr_mosi_data", 64'(mosi_log[15:0]), 64'(16'h1234));
        check_val("wr_rvalid", 64'(rv_cnt), 64'(0));
        check_val("wr_cs_low", 64'(cs_low), 64'(389));

        // Undefined type code behaves as INS: no capture even with MISO high.
        cur_len = 8;
        miso_bits = {8'hFF, 56'h0};
        send({OP_READ_STATUS, 24'h0}, 9'd8, 3'd5, 16'd16);
        wait_done();
        check_val("t5_rises", 64'(rises), 64'(16));
        check_val("t5_rvalid", 64'(rv_cnt), 64'(0));
        check_val("t5_wreq", 64'(req_cnt), 64'(0));

        // Zero-length command: CS never falls, ready after LOAD + gap.
        send(32'h0, 9'd0, SPI_INS, 16'd0);
        check_val("n0_cs_t1", 64'(spi_cs), 64'(1));
        wait_done();
        check_val("n0_cs_low", 64'(cs_low), 64'(0));
        check_val("n0_rises", 64'(rises), 64'(0));
        check_val("n0_busy", 64'(busy), 64'(5));

        // clk_len shorter than op_len: the instruction length wins.
        cur_len = 8;
        miso_bits = '0;
        send({OP_WRITE_EN, 24'h0}, 9'd8, SPI_INS, 16'd4);
        wait_done();
        check_val("short_rises", 64'(rises), 64'(8));
        check_val("short_mosi", 64'(mosi_log[7:0]), 64'(8'h06));

        // op_len above the word width is clamped to 32 bits.
        send({OP_SECT_ERASE, 24'h123456}, 9'd40, SPI_INS, 16'd0);
        wait_done();
        check_val("clamp_rises", 64'(rises), 64'(32));
        check_val("clamp_mosi", 64'(mosi_log[31:0]), 64'h2012_3456);

        // Reset in the middle of a page program, then a normal command.
        cur_len = 32;
        wr_fifo[0] = 8'h12;
        wr_fifo[1] = 8'h34;
        send({OP_PAGE_PROG, 24'h000100}, 9'd32, SPI_WRITE, 16'd48);
        n = 0;
        while (rises < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_reached_bit20", 64'(rises >= 20), 64'(1));
        rst = 1'b1;
        #1;
        check_val("mid_cs", 64'(spi_cs), 64'(1));
        check_val("mid_sclk", 64'(spi_clk), 64'(0));
        check_val("mid_ready", 64'(ready), 64'(1));
        check_val("mid_mosi", 64'(spi_mosi), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        cur_len = 8;
        miso_bits = '0;
        send({OP_WRITE_EN, 24'h0}, 9'd8, SPI_INS, 16'd8);
        wait_done();
        check_val("post_rises", 64'(rises), 64'(8));
        check_val("post_mosi", 64'(mosi_log[7:0]), 64'(8'h06));
        check_val("post_cs_low", 64'(cs_low), 64'(69));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
